// File: rtl/pwm_pkg.sv
// Shared widths, reset defaults, dead-time FSM encoding and config payload for the PWM core.
package pwm_pkg;

    localparam int unsigned CNT_W      = 16;
    localparam int unsigned DEAD_W     = 8;
    localparam int unsigned DEF_PERIOD = 1000;
    localparam int unsigned DEF_DUTY   = 500;
    localparam int unsigned DEF_DEAD   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        H_ON = 2'd1,
        DEAD = 2'd2,
        L_ON = 2'd3
    } pwm_state_e;

    typedef struct packed {
        logic [CNT_W-1:0]  period;
        logic [CNT_W-1:0]  duty;
        logic [DEAD_W-1:0] dead;
    } pwm_cfg_t;

endpackage

// File: rtl/pwm_deadtime.sv
// Complementary gate drive from the raw compare, with a both-low gap of
// max(dead,1) i_clk cycles inserted on every side change.
module pwm_deadtime
    import pwm_pkg::*;
(
    input  logic              i_clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic              i_raw,
    input  logic [DEAD_W-1:0] i_dead,
    output logic              o_pwm_h,
    output logic              o_pwm_l
);

    pwm_state_e        state_q, state_d;
    logic [DEAD_W-1:0] dcnt_q, dcnt_d;
    logic [DEAD_W-1:0] dead_load_c;
    logic              h_d, l_d;

    // DEAD exits when dcnt reaches zero, so load one less than the gap length
    assign dead_load_c = (i_dead == '0) ? '0 : i_dead - DEAD_W'(1);

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dcnt_q  <= '0;
            o_pwm_h <= 1'b0;
            o_pwm_l <= 1'b0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            o_pwm_h <= h_d;
            o_pwm_l <= l_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        if (!i_en) begin
            state_d = IDLE;
            dcnt_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = DEAD;
                    dcnt_d  = dead_load_c;
                end
                H_ON: if (!i_raw) begin
                    state_d = DEAD;
                    dcnt_d  = dead_load_c;
                end
                L_ON: if (i_raw) begin
                    state_d = DEAD;
                    dcnt_d  = dead_load_c;
                end
                DEAD: begin
                    if (dcnt_q == '0) begin
                        state_d = i_raw ? H_ON : L_ON;
                    end else begin
                        dcnt_d = dcnt_q - DEAD_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs decoded from the next state so the registers track state_q exactly
    always_comb begin
        h_d = (state_d == H_ON);
        l_d = (state_d == L_ON);
    end

endmodule

// File: rtl/pwm_core.sv
// Single-channel PWM: tick edge detect, period counter, shadowed config
// handshake and duty compare feeding the dead-time stage.
module pwm_core
    import pwm_pkg::*;
(
    input  logic              i_clk,
    input  logic              rst_n,
    input  logic              i_tick_clk,
    input  logic              i_en,
    input  logic              i_cfg_valid,
    output logic              o_cfg_ready,
    input  logic [CNT_W-1:0]  i_period,
    input  logic [CNT_W-1:0]  i_duty,
    input  logic [DEAD_W-1:0] i_dead,
    output logic              o_pwm_h,
    output logic              o_pwm_l,
    output logic              o_period_end
);

    logic             tick_prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    pwm_cfg_t         act_q, act_d;
    pwm_cfg_t         shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             step_c, wrap_c, accept_c, raw_c;

    assign step_c   = i_tick_clk & ~tick_prev_q;
    assign wrap_c   = i_en & step_c & (act_q.period != '0)
                    & (cnt_q == act_q.period - CNT_W'(1));
    assign accept_c = i_cfg_valid & ~pending_q;
    assign raw_c    = (act_q.period != '0) & (cnt_q < act_q.duty);

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_prev_q  <= 1'b0;
            cnt_q        <= '0;
            act_q        <= '{period: CNT_W'(DEF_PERIOD), duty: CNT_W'(DEF_DUTY),
                              dead: DEAD_W'(DEF_DEAD)};
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            o_cfg_ready  <= 1'b1;
            o_period_end <= 1'b0;
        end else begin
            tick_prev_q  <= i_tick_clk;
            cnt_q        <= cnt_d;
            act_q        <= act_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            o_cfg_ready  <= ~pending_d;
            o_period_end <= wrap_c;
        end
    end

    // Counter plus shadow copy; pending_q gates the copy so a same-cycle accept waits a wrap
    always_comb begin
        cnt_d     = cnt_q;
        act_d     = act_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        if (!i_en) begin
            cnt_d = '0;
        end else if (step_c) begin
            cnt_d = (wrap_c || act_q.period == '0) ? '0 : cnt_q + CNT_W'(1);
        end
        if (pending_q && (wrap_c || !i_en)) begin
            act_d     = shadow_q;
            pending_d = 1'b0;
        end else if (accept_c) begin
            shadow_d  = '{period: i_period, duty: i_duty, dead: i_dead};
            pending_d = 1'b1;
        end
    end

    pwm_deadtime u_deadtime (
        .i_clk   (i_clk),
        .rst_n   (rst_n),
        .i_en    (i_en),
        .i_raw   (raw_c),
        .i_dead  (act_q.dead),
        .o_pwm_h (o_pwm_h),
        .o_pwm_l (o_pwm_l)
    );

endmodule
